// File: rtl/mult_drain.sv
// mult_drain: result collector and credit gate for a free-running pipelined
// FP multiplier. Operand validity rides a LATENCY-deep shift register that
// tracks the multiplier, arriving products land in a first-word-fall-through
// FIFO, and in_ready is withheld whenever one more launch could overflow it.
// Sticky IEEE status flags accumulate for software.

`ifndef MULT_DATA_WIDTH
`define MULT_DATA_WIDTH 32
`endif
`ifndef PIPELINE_ORDER
`define PIPELINE_ORDER 4
`endif

module mult_drain #(
  parameter int DATA_WIDTH = `MULT_DATA_WIDTH,
  parameter int LATENCY    = `PIPELINE_ORDER,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] mult_z,
  input  logic [7:0]            mult_status,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [7:0]            out_status,
  output logic [7:0]            sticky_stat,
  input  logic                  sticky_clr,
  output logic [CNT_W-1:0]      occupancy
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W = DATA_WIDTH + 8;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  logic [LATENCY-1:0] vld_sr;
  logic [CNT_W-1:0]   reserved;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] head;
  logic               fire_in;
  logic               fire_out;
  logic               capture;

  // Explicit wrap so DEPTH does not have to be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == LAST_C) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign fire_in   = in_valid && in_ready;
  assign fire_out  = out_valid && out_ready;
  assign capture   = vld_sr[LATENCY-1];

  // Credit gate depends only on the reserved register, never on in_valid/out_ready.
  assign in_ready  = (reserved < DEPTH_C);

  assign out_valid = (occupancy != '0);
  assign head      = mem[rd_ptr];
  assign out_data  = head[DATA_WIDTH-1:0];
  assign out_status = head[ENTRY_W-1:DATA_WIDTH];

  // Launch side: validity shadow of the multiplier pipeline, bit 0 is the launch cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= fire_in;
      for (int i = 1; i < LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
    end
  end

  // Credits: every launched operand holds a slot until its result is popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reserved <= '0;
    end else begin
      case ({fire_in, fire_out})
        2'b10:   reserved <= reserved + 1'b1;
        2'b01:   reserved <= reserved - 1'b1;
        default: reserved <= reserved;
      endcase
    end
  end

  // Capture side: write arriving product into the FIFO storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (capture) begin
      mem[wr_ptr] <= {mult_status, mult_z};
      wr_ptr      <= ptr_next(wr_ptr);
    end
  end

  // Drain side: advance the head on each accepted pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
    end else if (fire_out) begin
      rd_ptr <= ptr_next(rd_ptr);
    end
  end

  // Occupancy: simultaneous capture and pop leaves the count unchanged (no bypass).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else begin
      case ({capture, fire_out})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Sticky flags: a capture in the clear cycle survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_stat <= '0;
    end else begin
      sticky_stat <= (sticky_clr ? 8'h00 : sticky_stat) | (capture ? mult_status : 8'h00);
    end
  end

`ifndef SYNTHESIS
  // The credit scheme guarantees these; a failure means the gate is broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(capture && occupancy == DEPTH_C));
  a_reserved_bound: assert property (@(posedge clk) disable iff (!rst_n)
    reserved <= DEPTH_C);
  a_occ_le_reserved: assert property (@(posedge clk) disable iff (!rst_n)
    occupancy <= reserved);
`endif

endmodule

// File: tb/tb_mult_drain.sv
// Bench for mult_drain: a free-running multiplier model feeds two instances
// (DEPTH=8 and DEPTH=5); a negedge scoreboard pairs pushes on fire_in with pops.
module tb_mult_drain;
  localparam int LAT = 4;
  localparam int DW  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [DW-1:0] in_z;
  logic [7:0]    in_st;
  logic [39:0]   mp [LAT];
  logic [DW-1:0] mult_z;
  logic [7:0]    mult_status;

  // Multiplier model: fixed LAT-cycle pipe, never stalls
  always @(posedge clk) begin
    mp[0] <= {in_st, in_z};
    for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
  end
  assign mult_z      = mp[LAT-1][31:0];
  assign mult_status = mp[LAT-1][39:32];

  logic          a_iv, a_ir, a_ov, a_or, a_clr;
  logic [DW-1:0] a_od;
  logic [7:0]    a_os, a_sticky;
  logic [3:0]    a_occ;
  logic          b_iv, b_ir, b_ov, b_or, b_clr;
  logic [DW-1:0] b_od;
  logic [7:0]    b_os, b_sticky;
  logic [2:0]    b_occ;

  mult_drain #(.DATA_WIDTH(DW), .LATENCY(LAT), .DEPTH(8)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir),
    .mult_z(mult_z), .mult_status(mult_status),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_status(a_os),
    .sticky_stat(a_sticky), .sticky_clr(a_clr), .occupancy(a_occ));

  mult_drain #(.DATA_WIDTH(DW), .LATENCY(LAT), .DEPTH(5)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir),
    .mult_z(mult_z), .mult_status(mult_status),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_status(b_os),
    .sticky_stat(b_sticky), .sticky_clr(b_clr), .occupancy(b_occ));

  int passed = 0;
  int total  = 0;
  int b_pops = 0;
  logic b_chk = 1'b0;
  logic [39:0] qa [$];
  logic [39:0] qb [$];
  logic [39:0] exp_a, exp_b;

  // Scoreboard: push on fire_in, pop and compare on fire_out
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (a_iv && a_ir) qa.push_back({in_st, in_z});
      if (b_iv && b_ir) qb.push_back({in_st, in_z});
      if (a_ov && a_or) begin
        total++;
        if (qa.size() == 0) $display("FAIL a_pop_unexpected: got %h required no output", {a_os, a_od});
        else begin
          exp_a = qa.pop_front();
          if ({a_os, a_od} !== exp_a) $display("FAIL a_pop_data: got %h required %h", {a_os, a_od}, exp_a);
          else passed++;
        end
      end
      if (b_ov && b_or) begin
        total++;
        b_pops++;
        if (qb.size() == 0) $display("FAIL b_pop_unexpected: got %h required no output", {b_os, b_od});
        else begin
          exp_b = qb.pop_front();
          if ({b_os, b_od} !== exp_b) $display("FAIL b_pop_data: got %h required %h", {b_os, b_od}, exp_b);
          else passed++;
        end
      end
      if (b_chk) begin
        total++;
        if (u_b.reserved > 3'd5 || b_occ > 3'd5)
          $display("FAIL b_bounds: got reserved=%0d occ=%0d required <=5", u_b.reserved, b_occ);
        else passed++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_iv = 0; a_or = 0; a_clr = 0; b_iv = 0; b_or = 0; b_clr = 0;
    in_z = '0; in_st = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if (a_ov !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", a_ov); else passed++;
    total++; if (a_ir !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", a_ir); else passed++;
    total++; if (a_occ !== 4'd0) $display("FAIL reset_occ: got %0d required 0", a_occ); else passed++;
    total++; if ({a_os, a_od} !== 40'd0) $display("FAIL reset_data: got %h required 0", {a_os, a_od}); else passed++;
    total++; if (a_sticky !== 8'h00) $display("FAIL reset_sticky: got %h required 00", a_sticky); else passed++;
    total++; if (b_ir !== 1'b1) $display("FAIL reset_b_in_ready: got %b required 1", b_ir); else passed++;
  endtask

  task automatic test_single();
    logic early;
    early = 1'b0;
    tick(); a_iv = 1; in_z = 32'h4040_0000; in_st = 8'h00;
    tick(); a_iv = 0; in_z = $urandom; in_st = 8'hff;
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      if (a_ov !== 1'b0) early = 1'b1;
      tick(); in_z = $urandom;
    end
    @(negedge clk);
    total++; if (early !== 1'b0) $display("FAIL single_early_valid: got 1 required 0 before cycle 5"); else passed++;
    total++; if (a_ov !== 1'b1) $display("FAIL single_valid_c5: got %b required 1", a_ov); else passed++;
    total++; if (a_od !== 32'h4040_0000) $display("FAIL single_data: got %h required 40400000", a_od); else passed++;
    total++; if (a_occ !== 4'd1) $display("FAIL single_occ: got %0d required 1", a_occ); else passed++;
    tick(); a_or = 1;
    tick(); a_or = 0;
    @(negedge clk);
    total++; if (a_occ !== 4'd0) $display("FAIL single_pop_occ: got %0d required 0", a_occ); else passed++;
    total++; if (a_ir !== 1'b1) $display("FAIL single_pop_ready: got %b required 1", a_ir); else passed++;
  endtask

  task automatic test_stream();
    int drops, first, last, npop;
    drops = 0; first = -1; last = -1; npop = 0;
    a_or = 1;
    for (int c = 0; c < 110; c++) begin
      tick();
      a_iv = (c < 100); in_z = 32'h1000_0000 + c; in_st = c[7:0];
      @(negedge clk);
      if (a_iv && !a_ir) drops++;
      if (a_ov) begin
        if (first < 0) first = c;
        last = c;
        npop++;
      end
    end
    tick(); a_or = 0; a_iv = 0;
    total++; if (drops != 0) $display("FAIL stream_ready_drop: got %0d drops required 0", drops); else passed++;
    total++; if (first != LAT + 1) $display("FAIL stream_first: got cycle %0d required %0d", first, LAT + 1); else passed++;
    total++; if (last != 100 + LAT) $display("FAIL stream_last: got cycle %0d required %0d", last, 100 + LAT); else passed++;
    total++; if (npop != 100) $display("FAIL stream_count: got %0d required 100", npop); else passed++;
  endtask

  task automatic test_backpressure();
    int fires;
    fires = 0;
    a_or = 0;
    for (int c = 0; c < 20; c++) begin
      tick(); a_iv = 1; in_z = 32'h2000_0000 + c; in_st = 8'h00;
      @(negedge clk);
      if (a_iv && a_ir) fires++;
    end
    total++; if (fires != 8) $display("FAIL bp_fires: got %0d required 8", fires); else passed++;
    total++; if (a_ir !== 1'b0) $display("FAIL bp_ready_low: got %b required 0", a_ir); else passed++;
    tick(); a_iv = 0;
    @(negedge clk);
    total++; if (a_occ !== 4'd8) $display("FAIL bp_occ_full: got %0d required 8", a_occ); else passed++;
    tick(); a_or = 1;
    @(negedge clk);
    total++; if (a_ir !== 1'b0) $display("FAIL bp_ready_pop_cycle: got %b required 0", a_ir); else passed++;
    tick();
    @(negedge clk);
    total++; if (a_ir !== 1'b1) $display("FAIL bp_ready_after_pop: got %b required 1", a_ir); else passed++;
    repeat (8) tick();
    a_or = 0;
    @(negedge clk);
    total++; if (a_occ !== 4'd0) $display("FAIL bp_drained_occ: got %0d required 0", a_occ); else passed++;
    total++; if (qa.size() != 0) $display("FAIL bp_lost: got %0d pending required 0", qa.size()); else passed++;
  endtask

  task automatic test_sticky();
    tick(); a_clr = 1;
    tick(); a_clr = 0;
    @(negedge clk);
    total++; if (a_sticky !== 8'h00) $display("FAIL sticky_clear0: got %h required 00", a_sticky); else passed++;
    a_or = 1;
    for (int c = 0; c < 10; c++) begin
      tick();
      a_iv  = (c < 2);
      in_st = (c == 0) ? 8'h20 : (c == 1) ? 8'h04 : 8'h80;
      in_z  = $urandom;
      a_clr = (c == 5) || (c == 7);
      @(negedge clk);
      if (c == 5) begin
        total++; if (a_sticky !== 8'h20) $display("FAIL sticky_first: got %h required 20", a_sticky); else passed++;
      end
      if (c == 6) begin
        total++; if (a_sticky !== 8'h04) $display("FAIL sticky_clr_capture: got %h required 04", a_sticky); else passed++;
      end
      if (c == 8) begin
        total++; if (a_sticky !== 8'h00) $display("FAIL sticky_clr_idle: got %h required 00", a_sticky); else passed++;
      end
    end
    tick(); a_iv = 0; a_clr = 0; a_or = 0;
    total++; if (qa.size() != 0) $display("FAIL sticky_pending: got %0d required 0", qa.size()); else passed++;
  endtask

  task automatic test_reset_midop();
    logic spur;
    spur = 1'b0;
    a_or = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      a_iv = (c < 2) || (c >= 7); in_st = 8'h01; in_z = 32'h3000_0000 + c;
    end
    @(negedge clk);
    total++; if (a_occ !== 4'd2) $display("FAIL midop_stored: got %0d required 2", a_occ); else passed++;
    total++; if (a_sticky !== 8'h01) $display("FAIL midop_sticky_pre: got %h required 01", a_sticky); else passed++;
    tick(); a_iv = 0; rst_n = 1'b0;
    #1;
    total++; if (a_ov !== 1'b0) $display("FAIL midop_rst_valid: got %b required 0", a_ov); else passed++;
    total++; if (a_ir !== 1'b1) $display("FAIL midop_rst_ready: got %b required 1", a_ir); else passed++;
    total++; if (a_occ !== 4'd0) $display("FAIL midop_rst_occ: got %0d required 0", a_occ); else passed++;
    total++; if ({a_sticky, a_os, a_od} !== 48'd0) $display("FAIL midop_rst_outs: got %h required 0", {a_sticky, a_os, a_od}); else passed++;
    qa.delete();
    tick(); tick(); rst_n = 1'b1;
    for (int k = 0; k < 2 * LAT; k++) begin
      @(negedge clk);
      if (a_ov !== 1'b0) spur = 1'b1;
      tick();
    end
    total++; if (spur !== 1'b0) $display("FAIL midop_spurious: got out_valid=1 required 0"); else passed++;
  endtask

  task automatic test_random();
    b_chk = 1'b1;
    b_pops = 0;
    for (int c = 0; c < 10000; c++) begin
      tick();
      b_iv  = ($urandom_range(0, 99) < 70);
      b_or  = ($urandom_range(0, 99) < ((c < 5000) ? 30 : 80));
      in_z  = $urandom;
      in_st = 8'($urandom);
    end
    tick(); b_iv = 0; b_or = 1;
    repeat (20) tick();
    b_or = 0; b_chk = 1'b0;
    @(negedge clk);
    total++; if (qb.size() != 0) $display("FAIL rand_pending: got %0d required 0", qb.size()); else passed++;
    total++; if (b_occ !== 3'd0) $display("FAIL rand_occ: got %0d required 0", b_occ); else passed++;
    total++; if (b_pops < 1000) $display("FAIL rand_pops: got %0d required >=1000", b_pops); else passed++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish required finish within bound");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_sticky();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
